// File: rtl/i2s_tx.sv
// Mono I2S transmitter: buffers datapath samples in a small FIFO and
// serializes each one MSB-first into both the left and right slots, with
// sck and ws generated locally from clk.
module i2s_tx #(
   parameter int unsigned DATA_W = 16,
   parameter int unsigned DEPTH  = 2,
   parameter int unsigned DIV_W  = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     enable,
   input  logic [DIV_W-1:0]         clk_period,
   input  logic signed [DATA_W-1:0] din,
   input  logic                     din_vld,
   output logic                     din_rdy,
   output logic                     sck,
   output logic                     ws,
   output logic                     sd,
   output logic                     underrun,
   output logic                     overrun
);

   localparam int unsigned AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW  = $clog2(DEPTH + 1);
   localparam int unsigned SW  = 2 * DATA_W;
   localparam int unsigned SLW = $clog2(SW);

   logic              en_q;
   logic [DIV_W-1:0]  div_q;
   logic [DIV_W-1:0]  cnt_q;
   logic [SLW-1:0]    slot_q;
   logic [SW-1:0]     shift_q;
   logic [DATA_W-1:0] last_q;
   logic [DATA_W-1:0] mem [DEPTH];
   logic [AW-1:0]     rd_ptr;
   logic [AW-1:0]     wr_ptr;
   logic [CW-1:0]     count_q;

   logic [DIV_W-1:0]  div_eff;
   logic              tick;
   logic              fall_tick;
   logic              frame_tick;
   logic              pop;
   logic              push;
   logic [CW-1:0]     count_nxt;
   logic [SLW-1:0]    slot_nxt;
   logic              ws_nxt;
   logic [SW-1:0]     shift_nxt;
   logic [DATA_W-1:0] head;

   // Divider, slot sequencing and FIFO control decisions for this cycle.
   always_comb begin
      div_eff    = div_q;
      tick       = 1'b0;
      fall_tick  = 1'b0;
      frame_tick = 1'b0;
      pop        = 1'b0;
      push       = 1'b0;
      head       = mem[rd_ptr];
      count_nxt  = count_q;
      slot_nxt   = slot_q;
      ws_nxt     = ws;
      shift_nxt  = shift_q;

      // On the first enabled cycle the divider comes straight from clk_period.
      if (!en_q) begin
         div_eff = (clk_period == '0) ? DIV_W'(1) : clk_period;
      end
      tick       = (cnt_q == div_eff - DIV_W'(1));
      fall_tick  = tick & sck;
      frame_tick = fall_tick & (slot_q == SLW'(SW - 1));
      pop        = frame_tick & (count_q != '0);
      push       = din_vld & ((count_q < CW'(DEPTH)) | pop);
      count_nxt  = count_q + CW'(push) - CW'(pop);
      slot_nxt   = (slot_q == SLW'(SW - 1)) ? '0 : slot_q + SLW'(1);
      ws_nxt     = (slot_nxt >= SLW'(DATA_W - 1)) && (slot_nxt <= SLW'(SW - 2));
      if (frame_tick) begin
         shift_nxt = pop ? {head, head} : {last_q, last_q};
      end else begin
         shift_nxt = shift_q << 1;
      end
   end

   // Control state and registered outputs; enable low holds everything idle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         en_q     <= 1'b0;
         div_q    <= DIV_W'(1);
         cnt_q    <= '0;
         slot_q   <= SLW'(SW - 1);
         shift_q  <= '0;
         last_q   <= '0;
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         count_q  <= '0;
         din_rdy  <= 1'b1;
         sck      <= 1'b0;
         ws       <= 1'b0;
         sd       <= 1'b0;
         underrun <= 1'b0;
         overrun  <= 1'b0;
      end else if (!enable) begin
         en_q     <= 1'b0;
         cnt_q    <= '0;
         slot_q   <= SLW'(SW - 1);
         shift_q  <= '0;
         last_q   <= '0;
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         count_q  <= '0;
         din_rdy  <= 1'b0;
         sck      <= 1'b0;
         ws       <= 1'b0;
         sd       <= 1'b0;
         underrun <= 1'b0;
         overrun  <= 1'b0;
      end else begin
         en_q     <= 1'b1;
         div_q    <= div_eff;
         cnt_q    <= tick ? '0 : cnt_q + DIV_W'(1);
         if (tick) begin
            sck <= ~sck;
         end
         if (fall_tick) begin
            slot_q  <= slot_nxt;
            ws      <= ws_nxt;
            shift_q <= shift_nxt;
            sd      <= shift_nxt[SW-1];
         end
         if (pop) begin
            rd_ptr <= rd_ptr + AW'(1);
            last_q <= head;
         end
         if (push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         count_q  <= count_nxt;
         din_rdy  <= (count_nxt < CW'(DEPTH));
         underrun <= frame_tick & (count_q == '0);
         overrun  <= din_vld & ~push;
      end
   end

   // Sample storage; contents are don't-care until written.
   always_ff @(posedge clk) begin
      if (enable && push) begin
         mem[wr_ptr] <= din;
      end
   end

endmodule
